// File: rtl/fp_pkg.sv
// Shared widths, constants and operand/result records for the FP adder front end.
// Every file in this block imports this package.
package fp_pkg;

    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;
    localparam int EXP_BIAS  = 127;
    localparam int EXP_MAX   = 255;
    localparam int ALIGN_SAT = 24;
    localparam int SHIFT_W   = $clog2(ALIGN_SAT + 1);

    // One operand after unpacking: effective exponent and mantissa with hidden bit.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
        logic             special;
    } fp_op_t;

    typedef struct packed {
        logic [MAN_W:0]     big_man;
        logic [MAN_W:0]     small_man;
        logic [SHIFT_W-1:0] shift;
        logic [EXP_W-1:0]   exp_big;
        logic               sign_res;
        logic               eff_sub;
        logic               sticky;
        logic               special;
    } align_out_t;

    // OR of the mantissa bits that a right shift by sh pushes out; sh = 24 covers all bits.
    function automatic logic sticky_bits(input logic [MAN_W:0] man, input logic [SHIFT_W-1:0] sh);
        logic [MAN_W+1:0] mask;
        mask = ((MAN_W + 2)'(1) << sh) - (MAN_W + 2)'(1);
        return |(man & mask[MAN_W:0]);
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single unpack: sign, effective exponent, hidden-bit mantissa.
// Denormals report exponent 1 so they align against normals without special casing.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [EXP_W+MAN_W:0] op,
    output fp_op_t               u
);

    logic [EXP_W-1:0] exp_raw;
    logic             hidden;

    always_comb begin
        exp_raw   = op[MAN_W +: EXP_W];
        hidden    = |exp_raw;
        u.sign    = op[EXP_W+MAN_W];
        u.exp     = hidden ? exp_raw : EXP_W'(1);
        u.man     = {hidden, op[MAN_W-1:0]};
        u.special = (exp_raw == EXP_W'(EXP_MAX));
    end

endmodule

// File: rtl/fp_align_prep.sv
// Two-stage unpack / magnitude compare-swap in front of the alignment shifter.
// Stage 1 holds unpacked operands, stage 2 holds the ordered pair, shift and sticky.
module fp_align_prep #(
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int MAN_W = fp_pkg::MAN_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic                       op_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MAN_W:0]             big_man,
    output logic [MAN_W:0]             small_man,
    output logic [fp_pkg::SHIFT_W-1:0] shift,
    output logic [EXP_W-1:0]           exp_big,
    output logic                       sign_res,
    output logic                       eff_sub,
    output logic                       sticky,
    output logic                       special
);
    import fp_pkg::*;

    logic [EXP_W+MAN_W:0] op_in [2];
    fp_op_t               op_un [2];

    assign op_in[0] = a;
    assign op_in[1] = b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        fp_unpack u_unpack (
            .op (op_in[gi]),
            .u  (op_un[gi])
        );
    end

    logic       s1_valid_q, s1_valid_d;
    fp_op_t     s1_a_q, s1_a_d;
    fp_op_t     s1_b_q, s1_b_d;
    logic       s1_op_sub_q, s1_op_sub_d;
    logic       out_valid_q, out_valid_d;
    align_out_t out_q, out_d;
    logic       s1_advance;

    // Ready ripples back combinationally from out_ready; there is no skid buffer.
    assign s1_advance = !out_valid_q | out_ready;
    assign in_ready   = !s1_valid_q | s1_advance;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_sub_d = s1_op_sub_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d      = op_un[0];
                s1_b_d      = op_un[1];
                s1_op_sub_d = op_sub;
            end
        end
    end

    logic                 swap;
    fp_op_t               big_op, small_op;
    logic [EXP_W-1:0]     diff;
    logic [SHIFT_W-1:0]   shift_c;

    always_comb begin
        // On equal magnitude A stays the big operand.
        swap     = {s1_b_q.exp, s1_b_q.man} > {s1_a_q.exp, s1_a_q.man};
        big_op   = swap ? s1_b_q : s1_a_q;
        small_op = swap ? s1_a_q : s1_b_q;
        diff     = big_op.exp - small_op.exp;
        shift_c  = (diff >= EXP_W'(ALIGN_SAT)) ? SHIFT_W'(ALIGN_SAT) : diff[SHIFT_W-1:0];

        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (s1_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d.big_man   = big_op.man;
                out_d.small_man = small_op.man;
                out_d.shift     = shift_c;
                out_d.exp_big   = big_op.exp;
                out_d.sign_res  = swap ? (s1_b_q.sign ^ s1_op_sub_q) : s1_a_q.sign;
                out_d.eff_sub   = s1_a_q.sign ^ s1_b_q.sign ^ s1_op_sub_q;
                out_d.sticky    = sticky_bits(small_op.man, shift_c);
                out_d.special   = s1_a_q.special | s1_b_q.special;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_sub_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_sub_q <= s1_op_sub_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign big_man   = out_q.big_man;
    assign small_man = out_q.small_man;
    assign shift     = out_q.shift;
    assign exp_big   = out_q.exp_big;
    assign sign_res  = out_q.sign_res;
    assign eff_sub   = out_q.eff_sub;
    assign sticky    = out_q.sticky;
    assign special   = out_q.special;

endmodule

// File: tb/tb_fp_align_prep.sv
// Scoreboard bench for fp_align_prep: accepted pairs push a model result, a monitor
// pops and compares on every output transfer; directed plan vectors plus random traffic.
module tb_fp_align_prep;

    typedef struct {
        logic [23:0] big_man;
        logic [23:0] small_man;
        logic [4:0]  shift;
        logic [7:0]  exp_big;
        logic        sign_res;
        logic        eff_sub;
        logic        sticky;
        logic        special;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] big_man;
    logic [23:0] small_man;
    logic [4:0]  shift;
    logic [7:0]  exp_big;
    logic        sign_res;
    logic        eff_sub;
    logic        sticky;
    logic        special;

    int   tests = 0;
    int   fails = 0;
    int   txn   = 0;
    exp_t exp_q[$];
    bit   rand_bp_en = 1'b0;

    fp_align_prep dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .big_man   (big_man),
        .small_man (small_man),
        .shift     (shift),
        .exp_big   (exp_big),
        .sign_res  (sign_res),
        .eff_sub   (eff_sub),
        .sticky    (sticky),
        .special   (special)
    );

    always #5 clk = ~clk;

    // Reference: order by numeric magnitude, cap the exponent gap, sticky as a remainder.
    function automatic exp_t model(input logic [31:0] fa, input logic [31:0] fb, input logic sub);
        exp_t   r;
        int     ea, eb, eh, el, d;
        longint ma, mb, ka, kb, mh, ml;
        bit     sw;
        ea = (fa[30:23] == 8'd0) ? 1 : int'(fa[30:23]);
        eb = (fb[30:23] == 8'd0) ? 1 : int'(fb[30:23]);
        ma = longint'(fa[22:0]) + ((fa[30:23] != 8'd0) ? longint'(8388608) : longint'(0));
        mb = longint'(fb[22:0]) + ((fb[30:23] != 8'd0) ? longint'(8388608) : longint'(0));
        ka = longint'(ea) * 16777216 + ma;
        kb = longint'(eb) * 16777216 + mb;
        sw = kb > ka;
        eh = sw ? eb : ea;
        el = sw ? ea : eb;
        mh = sw ? mb : ma;
        ml = sw ? ma : mb;
        d  = eh - el;
        if (d > 24) d = 24;
        r.big_man   = mh[23:0];
        r.small_man = ml[23:0];
        r.shift     = d[4:0];
        r.exp_big   = eh[7:0];
        r.sticky    = (ml % (longint'(1) << d)) != 0;
        r.eff_sub   = fa[31] ^ fb[31] ^ sub;
        r.sign_res  = sw ? (fb[31] ^ sub) : fa[31];
        r.special   = (fa[30:23] == 8'hFF) || (fb[30:23] == 8'hFF);
        return r;
    endfunction

    function automatic exp_t cur_out();
        exp_t r;
        r.big_man   = big_man;
        r.small_man = small_man;
        r.shift     = shift;
        r.exp_big   = exp_big;
        r.sign_res  = sign_res;
        r.eff_sub   = eff_sub;
        r.sticky    = sticky;
        r.special   = special;
        return r;
    endfunction

    function automatic bit same(input exp_t x, input exp_t y);
        return x.big_man === y.big_man && x.small_man === y.small_man && x.shift === y.shift &&
               x.exp_big === y.exp_big && x.sign_res === y.sign_res && x.eff_sub === y.eff_sub &&
               x.sticky === y.sticky && x.special === y.special;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Input side of the scoreboard: a pair seen valid&ready here transfers on the next edge.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && in_valid && in_ready) exp_q.push_back(model(a, b, op_sub));
    end

    // Output side: compare every transfer, and check stalled outputs stay bit-stable.
    initial begin
        exp_t snap;
        exp_t e;
        exp_t c;
        bit   held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                held = 1'b0;
            end else begin
                c = cur_out();
                if (held && out_valid) begin
                    tests++;
                    if (!same(c, snap)) begin
                        fails++;
                        $display("[TB] FAIL stall_hold: got big=%h sh=%0d, held big=%h sh=%0d",
                                 c.big_man, c.shift, snap.big_man, snap.shift);
                    end
                end
                if (out_valid && out_ready) begin
                    tests++;
                    txn++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL out_txn %0d: unexpected output big=%h", txn, c.big_man);
                    end else begin
                        e = exp_q.pop_front();
                        if (!same(c, e)) fails++;
                        $display("[TB] txn %0d %s big=%h/%h small=%h/%h sh=%0d/%0d exp=%0d/%0d sr=%b/%b es=%b/%b st=%b/%b sp=%b/%b",
                                 txn, same(c, e) ? "ok" : "FAIL out_txn", c.big_man, e.big_man,
                                 c.small_man, e.small_man, c.shift, e.shift, c.exp_big, e.exp_big,
                                 c.sign_res, e.sign_res, c.eff_sub, e.eff_sub, c.sticky, e.sticky,
                                 c.special, e.special);
                    end
                end
                held = out_valid && !out_ready;
                snap = c;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge, in_valid left high.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic top, output int waited);
        bit done = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_;
        op_sub   = top;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 500) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL send_timeout: in_ready=%b, expected 1 within 500 cycles", in_ready);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic rand_pair(output logic [31:0] ra, output logic [31:0] rb);
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        int          sel, t;
        sel = $urandom_range(0, 9);
        if (sel == 0)      ea = 8'd0;
        else if (sel == 1) ea = 8'hFF;
        else               ea = 8'($urandom_range(1, 254));
        if ($urandom_range(0, 3) == 0) begin
            eb = 8'($urandom_range(0, 255));
        end else begin
            t = int'(ea) + int'($urandom_range(0, 60)) - 30;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            eb = t[7:0];
        end
        fa = 23'($urandom);
        fb = ($urandom_range(0, 7) == 0) ? fa : 23'($urandom);
        if ($urandom_range(0, 9) == 0) fb = 23'($urandom_range(0, 1));
        ra = {1'($urandom), ea, fa};
        rb = {1'($urandom), eb, fb};
    endtask

    initial begin
        logic [31:0] pa [9];
        logic [31:0] pb [9];
        logic        ps [9];
        logic [31:0] ra, rb;
        int          w, wsum;
        bit          seen;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_payload", {big_man, small_man, shift, exp_big, sign_res, eff_sub, sticky, special} != 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Plan vectors back to back with a free-running sink: no wait cycles allowed.
        pa[0] = 32'h3F800000; pb[0] = 32'h3F800000; ps[0] = 1'b0;
        pa[1] = 32'h3F800000; pb[1] = 32'h40800000; ps[1] = 1'b1;
        pa[2] = 32'h40000000; pb[2] = 32'h3F800001; ps[2] = 1'b0;
        pa[3] = 32'h4B800000; pb[3] = 32'h3F800001; ps[3] = 1'b0;
        pa[4] = 32'h7F800000; pb[4] = 32'h3F800000; ps[4] = 1'b0;
        pa[5] = 32'h00000001; pb[5] = 32'h00800000; ps[5] = 1'b0;
        pa[6] = 32'hC0400000; pb[6] = 32'h40400000; ps[6] = 1'b1;
        pa[7] = 32'h3F800000; pb[7] = 32'h00000000; ps[7] = 1'b1;
        pa[8] = 32'h80000003; pb[8] = 32'h7FC00000; ps[8] = 1'b0;
        out_ready = 1'b1;
        wsum = 0;
        for (int i = 0; i < 9; i++) begin
            send(pa[i], pb[i], ps[i], w);
            wsum += w;
        end
        idle();
        check("full_rate_waits", wsum, 0);
        drain("directed_drain");

        // Four pairs into a stalled sink: stage 1 and output fill, then in_ready drops.
        out_ready = 1'b0;
        fork
            begin
                send(32'h3F800000, 32'h40000000, 1'b0, w);
                send(32'h41200000, 32'h3DCCCCCD, 1'b1, w);
                send(32'hC2C80000, 32'h42C80000, 1'b0, w);
                send(32'h00400000, 32'h80200000, 1'b1, w);
                idle();
            end
            begin
                seen = 1'b0;
                for (int n = 0; n < 50 && !seen; n++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                check("bp_first_valid", seen, 1);
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    check("bp_in_ready_low", in_ready, 0);
                    check("bp_out_valid_high", out_valid, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Random traffic with random sink stalls and random source gaps.
        rand_bp_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rand_pair(ra, rb);
            send(ra, rb, 1'($urandom), w);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();
        rand_bp_en = 1'b0;
        drain("rand_drain");

        // Reset with both stages full: everything clears immediately, nothing stale survives.
        out_ready = 1'b0;
        send(32'h40490FDB, 32'h3F000000, 1'b0, w);
        send(32'h447A0000, 32'h3A83126F, 1'b1, w);
        idle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_payload", {big_man, small_man, shift, exp_big, sign_res, eff_sub, sticky, special} != 0, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rerst_in_ready", in_ready, 1);
        check("rerst_out_valid", out_valid, 0);
        out_ready = 1'b1;
        send(32'h3F800000, 32'h40800000, 1'b1, w);
        idle();
        check("lat_stage1_only", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_out_valid", out_valid, 1);
        drain("rerst_drain");
        check("txn_total", txn, 9 + 4 + 200 + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
